// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller states, S-box and GF(2^8) helpers
// used by the round datapath and the column-mixing logic.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    // Element 0 sits at the MSB end, so SBOX[b] is the forward S-box entry for byte b.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Column packed as {a0, a1, a2, a3}, a0 being row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
        b1 = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
        b2 = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
        b3 = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round) and AddRoundKey. Byte i of a block lives at bits [127-8i -: 8].
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    genvar gi;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            assign sb[127-8*gi -: 8] = sub_byte(st[127-8*gi -: 8]);
        end

        // Row r rotates left by r columns: out(r,c) = in(r, (c+r) mod 4).
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mc[127-32*gi -: 32] = mix_column(sr[127-32*gi -: 32]);
        end

        for (gi = 0; gi < 16; gi++) begin : g_ark
            assign result[127-8*gi -: 8] = (last ? sr[127-8*gi -: 8] : mc[127-8*gi -: 8])
                                           ^ rk[127-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock against an external key store,
// with valid/ready handshakes on the plaintext and ciphertext sides.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ctrl_state_t  state_reg, state_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic [127:0] st_reg, st_next;
    logic         out_valid_reg, out_valid_next;

    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (rnd_reg == LAST_RND);

    aes_round u_round (
        .st     (st_reg),
        .rk     (rk_data),
        .last   (last_round),
        .result (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rnd_reg       <= 4'd0;
            st_reg        <= 128'd0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rnd_reg       <= rnd_next;
            st_reg        <= st_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rnd_next       = rnd_reg;
        st_next        = st_reg;
        out_valid_next = out_valid_reg;
        rk_idx         = 4'd0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    st_next    = in_block ^ rk_data;
                    rnd_next   = 4'd1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = rnd_reg;
                st_next = round_out;
                if (last_round) begin
                    rnd_next   = 4'd0;
                    state_next = DONE;
                end else begin
                    rnd_next = rnd_reg + 4'd1;
                end
            end
            DONE: begin
                // out_valid is registered, so it rises one cycle after entering DONE;
                // out_ready is only honoured once it is visible.
                if (!out_valid_reg) begin
                    out_valid_next = 1'b1;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_block = out_valid_reg ? st_reg : 128'd0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl using FIPS-197 vectors and a behavioural key store.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = 128'd0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;

    logic [127:0] rkeys [0:15];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    aes_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk_data = rkeys[rk_idx];

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0]), sub_byte(t[31:24])}
                    ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rkeys[r] = 128'd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers pt until accepted; acc_edge is the number of the accepting clock edge.
    task automatic do_accept(input logic [127:0] pt, output int acc_edge);
        in_block = pt;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !in_ready; k++) step();
        acc_edge = cyc + 1;
        step();
        in_valid = 1'b0;
    endtask

    // Returns edges from acceptance to first visible out_valid, or -1 on timeout.
    task automatic wait_out(input int acc_edge, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                lat = cyc - acc_edge;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_block = PT_B; out_ready = 1'b0;
        step(); step();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_block !== 128'd0) begin miscompares++; $display("FAIL reset_out_block: got %h expected 0", out_block); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (rk_idx !== 4'd0) begin miscompares++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept: busy got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_fips_b();
        int acc, lat;
        expand_key(KEY_B);
        out_ready = 1'b1;
        do_accept(PT_B, acc);
        wait_out(acc, lat);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL b_latency: got %0d expected 11", lat); end
        vectors++; if (out_block !== CT_B) begin miscompares++; $display("FAIL b_cipher: got %h expected %h", out_block, CT_B); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b_busy_done: got %b expected 1", busy); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b_out_valid_drop: got %b expected 0", out_valid); end
        vectors++; if (out_block !== 128'd0) begin miscompares++; $display("FAIL b_out_block_zero: got %h expected 0", out_block); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b_in_ready_after: got %b expected 1", in_ready); end
        $display("test_fips_b: latency %0d", lat);
    endtask

    task automatic test_fips_c();
        int acc, lat;
        expand_key(KEY_C);
        out_ready = 1'b1;
        do_accept(PT_C, acc);
        wait_out(acc, lat);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL c_latency: got %0d expected 11", lat); end
        vectors++; if (out_block !== CT_C) begin miscompares++; $display("FAIL c_cipher: got %h expected %h", out_block, CT_C); end
        step();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL c_in_ready_after: got %b expected 1", in_ready); end
        $display("test_fips_c: latency %0d", lat);
    endtask

    task automatic test_backpressure();
        int acc, lat;
        expand_key(KEY_B);
        out_ready = 1'b0;
        do_accept(PT_B, acc);
        wait_out(acc, lat);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL bp_latency: got %0d expected 11", lat); end
        in_valid = 1'b1; in_block = PT_C;
        for (int k = 0; k < 20; k++) begin
            step();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
            vectors++; if (out_block !== CT_B) begin miscompares++; $display("FAIL bp_hold_block[%0d]: got %h expected %h", k, out_block, CT_B); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", k, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        $display("test_backpressure: released after 20 stalled cycles");
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        bit found;
        expand_key(KEY_B);
        out_ready = 1'b1;
        do_accept(PT_B, acc);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rk_idx == 4'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL mid_reach_rnd5: got %b expected 1", found); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
        vectors++; if (rk_idx !== 4'd0) begin miscompares++; $display("FAIL mid_rk_idx: got %0d expected 0", rk_idx); end
        do_accept(PT_B, acc);
        wait_out(acc, lat);
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL mid_latency: got %0d expected 11", lat); end
        vectors++; if (out_block !== CT_B) begin miscompares++; $display("FAIL mid_cipher: got %h expected %h", out_block, CT_B); end
        step();
        $display("test_reset_mid: recovered, latency %0d", lat);
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int acc_k [2];
        int rk_log [48];
        logic [127:0] outs [2];
        int nacc, nout;
        expand_key(KEY_B);
        acc = '{0, 0}; acc_k = '{0, 0}; outs = '{128'd0, 128'd0};
        nacc = 0; nout = 0;
        out_ready = 1'b1; in_block = PT_B; in_valid = 1'b1;
        for (int k = 0; k < 48; k++) begin
            rk_log[k] = int'(rk_idx);
            if (in_valid && in_ready && nacc < 2) begin
                acc[nacc] = cyc + 1;
                acc_k[nacc] = k;
                nacc++;
            end
            if (out_valid && nout < 2) begin
                outs[nout] = out_block;
                nout++;
            end
            step();
            if (nacc == 2) in_valid = 1'b0;
        end
        vectors++; if (nacc !== 2) begin miscompares++; $display("FAIL b2b_accepts: got %0d expected 2", nacc); end
        vectors++; if (acc[1] - acc[0] !== 13) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 13", acc[1] - acc[0]); end
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r <= 10; r++) begin
                vectors++;
                if (rk_log[acc_k[b] + r] !== r) begin
                    miscompares++;
                    $display("FAIL b2b_rk_idx blk%0d step%0d: got %0d expected %0d", b, r, rk_log[acc_k[b] + r], r);
                end
            end
        end
        vectors++; if (nout !== 2) begin miscompares++; $display("FAIL b2b_outputs: got %0d expected 2", nout); end
        vectors++; if (outs[0] !== CT_B) begin miscompares++; $display("FAIL b2b_cipher0: got %h expected %h", outs[0], CT_B); end
        vectors++; if (outs[1] !== CT_B) begin miscompares++; $display("FAIL b2b_cipher1: got %h expected %h", outs[1], CT_B); end
        $display("test_back_to_back: accepts at edges %0d and %0d", acc[0], acc[1]);
    endtask

    task automatic test_ignored_input();
        int acc, lat;
        expand_key(KEY_B);
        out_ready = 1'b1;
        do_accept(PT_B, acc);
        step(); step(); step();
        in_block = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ign_in_ready: got %b expected 0", in_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy: got %b expected 1", busy); end
        wait_out(acc, lat);
        in_valid = 1'b0;
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL ign_latency: got %0d expected 11", lat); end
        vectors++; if (out_block !== CT_B) begin miscompares++; $display("FAIL ign_cipher: got %h expected %h", out_block, CT_B); end
        step();
        $display("test_ignored_input: cipher %h", CT_B);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rkeys[r] = 128'd0;
        test_reset();
        test_fips_b();
        test_fips_c();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_ignored_input();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
